// File: rtl/astack_seq_if.sv
// rtl/astack_seq_if.sv - command and astack-side signal bundle for astack_seq
interface astack_seq_if #(
    parameter int W = 16
);
    logic         cmd_valid;
    logic         cmd_ready;
    logic [3:0]   cmd_op;
    logic [W-1:0] cmd_imm;
    logic [2:0]   cmd_n;
    logic         stk_cs;
    logic [2:0]   stk_mode;
    logic [2:0]   stk_dsel;
    logic [W-1:0] stk_r0in;
    logic [W-1:0] stk_r1in;
    logic [W-1:0] stk_r0out;
    logic [W-1:0] stk_r1out;

    modport master (
        output cmd_valid, cmd_op, cmd_imm, cmd_n, stk_r0out, stk_r1out,
        input  cmd_ready, stk_cs, stk_mode, stk_dsel, stk_r0in, stk_r1in
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_imm, cmd_n, stk_r0out, stk_r1out,
        output cmd_ready, stk_cs, stk_mode, stk_dsel, stk_r0in, stk_r1in
    );
endinterface

// File: rtl/astack_seq.sv
// rtl/astack_seq.sv - stack-machine opcode sequencer for astack; ASTACK_SEQ_MUL_EN enables MUL (op 13)
module astack_seq #(
    parameter int W  = 16,
    parameter int D  = 16,
    localparam int DW = $clog2(D + 1)
) (
    input  logic          clk,
    input  logic          rst,
    astack_seq_if.slave   bus,
    output logic          done,
    output logic          err,
    output logic [1:0]    err_code,
    output logic          err_sticky,
    output logic [DW-1:0] depth
);
    localparam logic [3:0] OP_NOP  = 4'd0,  OP_LIT  = 4'd1,  OP_DROP = 4'd2,  OP_DUP  = 4'd3;
    localparam logic [3:0] OP_SWAP = 4'd4,  OP_OVER = 4'd5,  OP_PICK = 4'd6,  OP_ROT  = 4'd7;
    localparam logic [3:0] OP_ADD  = 4'd8,  OP_SUB  = 4'd9,  OP_AND  = 4'd10, OP_OR   = 4'd11;
    localparam logic [3:0] OP_XOR  = 4'd12, OP_MUL  = 4'd13, OP_REPL = 4'd14;

    localparam logic [2:0] M_NONE = 3'd0, M_PUSH = 3'd1, M_POP = 3'd2, M_REP1 = 3'd3;
    localparam logic [2:0] M_REP2 = 3'd4, M_POPREP = 3'd5, M_BUB = 3'd6;

    typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE} state_t;
    state_t state, state_nxt;

    logic [3:0]   op_q;
    logic [W-1:0] imm_q, t_q, x_q;
    logic [2:0]   n_q;
    logic         legal_q, push_q, pop_q, sticky_q;
    logic [1:0]   code_q, err_code_q;

    logic [3:0]   need;
    logic         pushes, pops, bad_op;
    logic [1:0]   chk_code;
    logic [2:0]   wr_mode;
    logic [W-1:0] wr_r0;

    // Legality of the offered command against the current depth: illegal, then underflow, then overflow.
    always_comb begin
        need   = 4'd0;
        pushes = 1'b0;
        pops   = 1'b0;
        bad_op = 1'b0;
        case (bus.cmd_op)
            OP_NOP:  ;
            OP_LIT:  pushes = 1'b1;
            OP_DROP: begin need = 4'd1; pops = 1'b1; end
            OP_DUP:  begin need = 4'd1; pushes = 1'b1; end
            OP_SWAP: need = 4'd2;
            OP_OVER: begin need = 4'd2; pushes = 1'b1; end
            OP_PICK: begin need = 4'(bus.cmd_n) + 4'd1; pushes = 1'b1; end
            OP_ROT:  need = 4'd3;
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin need = 4'd2; pops = 1'b1; end
`ifdef ASTACK_SEQ_MUL_EN
            OP_MUL:  begin need = 4'd2; pops = 1'b1; end
`endif
            OP_REPL: need = 4'd1;
            default: bad_op = 1'b1;
        endcase
        if (bad_op)
            chk_code = 2'd3;
        else if (32'(depth) < 32'(need))
            chk_code = 2'd1;
        else if (pushes && (32'(depth) == D))
            chk_code = 2'd2;
        else
            chk_code = 2'd0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (bus.cmd_valid) state_nxt = S_READ;
            S_READ:  state_nxt = S_WRITE;
            S_WRITE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q       <= OP_NOP;
            imm_q      <= '0;
            n_q        <= '0;
            t_q        <= '0;
            x_q        <= '0;
            legal_q    <= 1'b0;
            code_q     <= 2'd0;
            push_q     <= 1'b0;
            pop_q      <= 1'b0;
            err_code_q <= 2'd0;
            sticky_q   <= 1'b0;
            depth      <= '0;
        end else begin
            case (state)
                S_IDLE: if (bus.cmd_valid) begin
                    op_q    <= bus.cmd_op;
                    imm_q   <= bus.cmd_imm;
                    n_q     <= bus.cmd_n;
                    legal_q <= (chk_code == 2'd0);
                    code_q  <= chk_code;
                    push_q  <= pushes;
                    pop_q   <= pops;
                end
                S_READ: begin
                    t_q <= bus.stk_r0out;
                    x_q <= bus.stk_r1out;
                end
                S_WRITE: begin
                    if (legal_q) begin
                        if (push_q)     depth <= depth + DW'(1);
                        else if (pop_q) depth <= depth - DW'(1);
                    end else begin
                        err_code_q <= code_q;
                        sticky_q   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // X is whatever entry dsel selected during READ: N, entry n for PICK, entry 2 for ROT.
    always_comb begin
        wr_mode = M_NONE;
        wr_r0   = '0;
        case (op_q)
            OP_LIT:  begin wr_mode = M_PUSH;   wr_r0 = imm_q; end
            OP_DROP: wr_mode = M_POP;
            OP_DUP:  begin wr_mode = M_PUSH;   wr_r0 = t_q; end
            OP_SWAP: begin wr_mode = M_REP2;   wr_r0 = x_q; end
            OP_OVER, OP_PICK: begin wr_mode = M_PUSH; wr_r0 = x_q; end
            OP_ROT:  begin wr_mode = M_BUB;    wr_r0 = x_q; end
            OP_ADD:  begin wr_mode = M_POPREP; wr_r0 = x_q + t_q; end
            OP_SUB:  begin wr_mode = M_POPREP; wr_r0 = x_q - t_q; end
            OP_AND:  begin wr_mode = M_POPREP; wr_r0 = x_q & t_q; end
            OP_OR:   begin wr_mode = M_POPREP; wr_r0 = x_q | t_q; end
            OP_XOR:  begin wr_mode = M_POPREP; wr_r0 = x_q ^ t_q; end
`ifdef ASTACK_SEQ_MUL_EN
            OP_MUL:  begin wr_mode = M_POPREP; wr_r0 = x_q * t_q; end
`endif
            OP_REPL: begin wr_mode = M_REP1;   wr_r0 = imm_q; end
            default: ;
        endcase
    end

    always_comb begin
        bus.cmd_ready = (state == S_IDLE);
        bus.stk_cs    = 1'b0;
        bus.stk_mode  = M_NONE;
        bus.stk_dsel  = 3'd0;
        bus.stk_r0in  = '0;
        bus.stk_r1in  = '0;
        done          = 1'b0;
        err           = 1'b0;
        case (state)
            S_READ: begin
                if (op_q == OP_PICK)     bus.stk_dsel = n_q;
                else if (op_q == OP_ROT) bus.stk_dsel = 3'd2;
                else                     bus.stk_dsel = 3'd1;
            end
            S_WRITE: begin
                done = legal_q;
                err  = ~legal_q;
                if (legal_q && (op_q != OP_NOP)) begin
                    bus.stk_cs   = 1'b1;
                    bus.stk_mode = wr_mode;
                    bus.stk_r0in = wr_r0;
                    bus.stk_r1in = t_q;
                    bus.stk_dsel = (op_q == OP_ROT) ? 3'd2 : 3'd0;
                end
            end
            default: ;
        endcase
        err_code   = (state == S_WRITE && !legal_q) ? code_q : err_code_q;
        err_sticky = sticky_q | (state == S_WRITE && !legal_q);
    end
endmodule
